// File: rtl/uart_pkg.sv
// Shared constants and types for the 16550-style FIFOs: LSR error-tag bit positions,
// default depth and the FCR receive trigger-level encoding.
package uart_pkg;

  localparam int unsigned ERR_PE = 0;
  localparam int unsigned ERR_FE = 1;
  localparam int unsigned ERR_BI = 2;

  localparam int unsigned FIFO_DEPTH_DEFAULT = 16;

  typedef enum logic [1:0] {
    TrigLvl1  = 2'd0,
    TrigLvl4  = 2'd1,
    TrigLvl8  = 2'd2,
    TrigLvl14 = 2'd3
  } trig_lvl_e;

  function automatic int unsigned trig_threshold(trig_lvl_e lvl);
    int unsigned thr;
    unique case (lvl)
      TrigLvl1:  thr = 1;
      TrigLvl4:  thr = 4;
      TrigLvl8:  thr = 8;
      TrigLvl14: thr = 14;
      default:   thr = 1;
    endcase
    return thr;
  endfunction

endpackage

// File: rtl/uart_fifo_mem.sv
// FIFO storage: synchronous write, asynchronous read, deliberately not reset.
module uart_fifo_mem #(
  parameter int unsigned Width = 11,
  parameter int unsigned Depth = 16,
  localparam int unsigned AddrW = $clog2(Depth)
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AddrW-1:0] waddr_i,
  input  logic [Width-1:0] wdata_i,
  input  logic [AddrW-1:0] raddr_i,
  output logic [Width-1:0] rdata_o
);

  logic [Width-1:0] mem_q [Depth];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/uart_fifo_param.sv
// 16550-compatible TX/RX FIFO: circular buffer with occupancy count, per-entry error tag,
// flush on clear or mode change, 16450 single-entry mode, trigger level and status flags.
module uart_fifo_param
  import uart_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ERR_W  = 3,
  parameter int unsigned DEPTH  = FIFO_DEPTH_DEFAULT,
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              en_i,
  input  logic              clr_i,
  input  logic              push_i,
  input  logic [DATA_W-1:0] din_i,
  input  logic [ERR_W-1:0]  err_in_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] dout_o,
  output logic [ERR_W-1:0]  err_out_o,
  output logic [CNT_W-1:0]  count_o,
  output logic              empty_o,
  output logic              full_o,
  input  logic [CNT_W-1:0]  threshold_i,
  output logic              thre_trigger_o,
  output logic              overrun_o,
  input  logic              overrun_clr_i,
  output logic              underrun_o,
  output logic              err_any_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned ENT_W = DATA_W + ERR_W;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : gen_depth_chk
    $fatal(1, "uart_fifo_param: DEPTH must be a power of two >= 2");
  end

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d, err_cnt_q, err_cnt_d, eff_depth;
  logic             overrun_q, overrun_d, underrun_q, underrun_d, thre_q, thre_d, en_q;
  logic             flush, empty, full, pop_ok, push_ok;
  logic [ENT_W-1:0] rdata;
  logic [DATA_W-1:0] head_data;
  logic [ERR_W-1:0]  head_err;

  // Toggling FIFO enable flushes, like the 16550 FCR[0].
  assign flush     = clr_i | (en_i != en_q);
  assign eff_depth = en_i ? CNT_W'(DEPTH) : CNT_W'(1);
  assign empty     = (count_q == '0);
  assign full      = (count_q == eff_depth);
  assign pop_ok    = pop_i & ~empty;
  assign push_ok   = push_i & (~full | pop_ok);
  assign {head_err, head_data} = rdata;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    err_cnt_d  = err_cnt_q;
    overrun_d  = overrun_q;
    underrun_d = 1'b0;
    thre_d     = 1'b0;
    if (flush) begin
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      count_d   = '0;
      err_cnt_d = '0;
      overrun_d = 1'b0;
    end else begin
      if (push_ok) wr_ptr_d = en_i ? wr_ptr_q + PTR_W'(1) : '0;
      if (pop_ok)  rd_ptr_d = en_i ? rd_ptr_q + PTR_W'(1) : '0;
      count_d    = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
      err_cnt_d  = err_cnt_q + CNT_W'(push_ok & (|err_in_i)) - CNT_W'(pop_ok & (|head_err));
      underrun_d = pop_i & empty;
      if (push_i & full & ~pop_ok) begin
        overrun_d = 1'b1;
      end else if (overrun_clr_i) begin
        overrun_d = 1'b0;
      end
      thre_d = (count_d >= threshold_i) && (threshold_i != '0);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      err_cnt_q  <= '0;
      overrun_q  <= 1'b0;
      underrun_q <= 1'b0;
      thre_q     <= 1'b0;
      en_q       <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      err_cnt_q  <= err_cnt_d;
      overrun_q  <= overrun_d;
      underrun_q <= underrun_d;
      thre_q     <= thre_d;
      en_q       <= en_i;
    end
  end

  uart_fifo_mem #(
    .Width(ENT_W),
    .Depth(DEPTH)
  ) u_mem (
    .clk_i  (clk_i),
    .we_i   (push_ok & ~flush),
    .waddr_i(wr_ptr_q),
    .wdata_i({err_in_i, din_i}),
    .raddr_i(rd_ptr_q),
    .rdata_o(rdata)
  );

  // Storage is not reset, so mask the head while empty to keep stale data hidden.
  assign dout_o         = empty ? '0 : head_data;
  assign err_out_o      = empty ? '0 : head_err;
  assign count_o        = count_q;
  assign empty_o        = empty;
  assign full_o         = full;
  assign thre_trigger_o = thre_q;
  assign overrun_o      = overrun_q;
  assign underrun_o     = underrun_q;
  assign err_any_o      = (err_cnt_q != '0);

endmodule

// File: tb/tb_uart_fifo_param.sv
// Self-checking bench for uart_fifo_param: queue-based reference model checked every cycle,
// directed corner sequences, a vector table for flush/16450 mode and randomized traffic.
module tb_uart_fifo_param;

  localparam int DEP = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0, clr = 1'b0, push = 1'b0, pop = 1'b0, ovc = 1'b0;
  logic [7:0] din = '0;
  logic [2:0] errin = '0;
  logic [4:0] thr = '0;

  logic [7:0] dout;
  logic [2:0] err_out;
  logic [4:0] count;
  logic       empty, full, thre, overrun, underrun, err_any;

  uart_fifo_param #(
    .DATA_W(8),
    .ERR_W (3),
    .DEPTH (DEP)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .en_i          (en),
    .clr_i         (clr),
    .push_i        (push),
    .din_i         (din),
    .err_in_i      (errin),
    .pop_i         (pop),
    .dout_o        (dout),
    .err_out_o     (err_out),
    .count_o       (count),
    .empty_o       (empty),
    .full_o        (full),
    .threshold_i   (thr),
    .thre_trigger_o(thre),
    .overrun_o     (overrun),
    .overrun_clr_i (ovc),
    .underrun_o    (underrun),
    .err_any_o     (err_any)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  // Reference model: queue of {err, data}, plus flag state.
  logic [10:0] mq[$];
  bit m_over, m_under, m_thre, m_enq;

  typedef struct {
    bit clr, en, push, pop;
    logic [7:0] din;
    logic [4:0] cnt;
    bit full, empty, over;
    logic [7:0] dout;
  } vec_t;
  vec_t tbl[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_over = 0; m_under = 0; m_thre = 0; m_enq = 0;
  endtask

  task automatic model_edge();
    int depth;
    bit fl, was_empty, was_full, pok, wok;
    depth = en ? DEP : 1;
    fl = clr || (en != m_enq);
    m_enq = en;
    if (fl) begin
      mq.delete();
      m_over = 0; m_under = 0; m_thre = 0;
    end else begin
      was_empty = (mq.size() == 0);
      was_full  = (mq.size() == depth);
      pok = pop && !was_empty;
      wok = push && (!was_full || pok);
      m_under = pop && was_empty;
      if (push && was_full && !pok) m_over = 1;
      else if (ovc) m_over = 0;
      if (pok) void'(mq.pop_front());
      if (wok) mq.push_back({errin, din});
      m_thre = (thr != 0) && (mq.size() >= int'(thr));
    end
  endtask

  task automatic check_all();
    int depth;
    bit any;
    logic [7:0] e_dout;
    logic [2:0] e_err;
    depth = en ? DEP : 1;
    any = 0;
    foreach (mq[i]) if (mq[i][10:8] != 0) any = 1;
    e_dout = (mq.size() != 0) ? mq[0][7:0] : 8'h00;
    e_err  = (mq.size() != 0) ? mq[0][10:8] : 3'b000;
    chk("count", count, mq.size());
    chk("empty", empty, mq.size() == 0);
    chk("full", full, mq.size() == depth);
    chk("dout", dout, e_dout);
    chk("err_out", err_out, e_err);
    chk("overrun", overrun, m_over);
    chk("underrun", underrun, m_under);
    chk("thre_trigger", thre, m_thre);
    chk("err_any", err_any, any);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  task automatic cyc(input bit pu, input bit po, input logic [7:0] d, input logic [2:0] er);
    push = pu; pop = po; din = d; errin = er;
    step();
    push = 0; pop = 0;
  endtask

  task automatic flush_pulse();
    clr = 1;
    cyc(0, 0, 8'h00, 3'b000);
    clr = 0;
  endtask

  // Called at a negedge: asserts reset between edges and checks outputs at once.
  task automatic async_reset();
    #2 rst_n = 0;
    #1;
    model_reset();
    check_all();
    chk("rst_dout", dout, 0);
    @(negedge clk);
    rst_n = 1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{0, 1, 1, 0, 8'hA1, 5'd1, 0, 0, 0, 8'hA1};
    tbl[1]  = '{0, 1, 1, 0, 8'hA2, 5'd2, 0, 0, 0, 8'hA1};
    tbl[2]  = '{0, 1, 1, 0, 8'hA3, 5'd3, 0, 0, 0, 8'hA1};
    tbl[3]  = '{0, 1, 1, 0, 8'hA4, 5'd4, 0, 0, 0, 8'hA1};
    tbl[4]  = '{0, 1, 1, 0, 8'hA5, 5'd5, 0, 0, 0, 8'hA1};
    tbl[5]  = '{1, 1, 1, 0, 8'hA6, 5'd0, 0, 1, 0, 8'h00};
    tbl[6]  = '{0, 0, 0, 0, 8'h00, 5'd0, 0, 1, 0, 8'h00};
    tbl[7]  = '{0, 0, 1, 0, 8'hB1, 5'd1, 1, 0, 0, 8'hB1};
    tbl[8]  = '{0, 0, 1, 0, 8'hB2, 5'd1, 1, 0, 1, 8'hB1};
    tbl[9]  = '{0, 0, 0, 1, 8'h00, 5'd0, 0, 1, 1, 8'h00};
    tbl[10] = '{0, 0, 1, 1, 8'hB3, 5'd1, 1, 0, 1, 8'hB3};
    tbl[11] = '{0, 0, 1, 1, 8'hB4, 5'd1, 1, 0, 1, 8'hB4};
    tbl[12] = '{0, 1, 0, 0, 8'h00, 5'd0, 0, 1, 0, 8'h00};
    tbl[13] = '{0, 1, 1, 0, 8'hC1, 5'd1, 0, 0, 0, 8'hC1};

    // Reset state, then enable FIFO mode.
    model_reset();
    @(negedge clk);
    check_all();
    rst_n = 1;
    en = 1;
    step();

    // Reset mid-traffic.
    for (int i = 0; i < 5; i++) cyc(1, 0, 8'h60 + 8'(i), 3'(i));
    async_reset();
    chk("rst_empty", empty, 1);
    step();

    // Fill and drain the full depth.
    for (int i = 0; i < 16; i++) cyc(1, 0, 8'(i), 3'b000);
    chk("full_at_16", full, 1);
    cyc(1, 0, 8'h10, 3'b000);
    chk("overrun_17th", overrun, 1);
    chk("count_17th", count, 16);
    for (int i = 0; i < 16; i++) begin
      chk("drain_order", dout, i);
      cyc(0, 1, 8'h00, 3'b000);
    end
    chk("drained_empty", empty, 1);
    cyc(0, 1, 8'h00, 3'b000);
    chk("underrun_pulse", underrun, 1);
    cyc(0, 0, 8'h00, 3'b000);
    chk("underrun_gone", underrun, 0);
    ovc = 1;
    cyc(0, 0, 8'h00, 3'b000);
    ovc = 0;
    chk("overrun_clr", overrun, 0);

    // Simultaneous push/pop across pointer wrap, at full and at empty.
    flush_pulse();
    for (int i = 0; i < 8; i++) cyc(1, 0, 8'h20 + 8'(i), 3'b000);
    for (int k = 0; k < 40; k++) begin
      chk("wrap_order", dout, 8'h20 + 8'(k));
      cyc(1, 1, 8'h28 + 8'(k), 3'b000);
    end
    chk("wrap_count", count, 8);
    for (int i = 0; i < 8; i++) cyc(1, 0, 8'h80 + 8'(i), 3'b000);
    cyc(1, 1, 8'h90, 3'b000);
    chk("pp_full_count", count, 16);
    chk("pp_full_no_ovr", overrun, 0);
    for (int i = 0; i < 16; i++) cyc(0, 1, 8'h00, 3'b000);
    cyc(1, 1, 8'h99, 3'b000);
    chk("pp_empty_count", count, 1);
    chk("pp_empty_underrun", underrun, 1);
    chk("pp_empty_dout", dout, 8'h99);

    // Error tags.
    flush_pulse();
    cyc(1, 0, 8'h41, 3'b010);
    cyc(1, 0, 8'h42, 3'b000);
    chk("err_any_set", err_any, 1);
    chk("err_out_head", err_out, 3'b010);
    cyc(0, 1, 8'h00, 3'b000);
    chk("err_any_clear", err_any, 0);
    chk("err_next_head", dout, 8'h42);

    // Trigger level.
    flush_pulse();
    thr = 5'd8;
    for (int i = 0; i < 7; i++) cyc(1, 0, 8'(i), 3'b000);
    chk("thre_7", thre, 0);
    cyc(1, 0, 8'h07, 3'b000);
    chk("thre_8", thre, 1);
    cyc(0, 1, 8'h00, 3'b000);
    chk("thre_pop", thre, 0);
    thr = 5'd0;
    cyc(0, 0, 8'h00, 3'b000);
    chk("thre_zero", thre, 0);

    // Flush / 16450 mode vector table.
    flush_pulse();
    for (int i = 0; i < 14; i++) begin
      clr = tbl[i].clr;
      en = tbl[i].en;
      cyc(tbl[i].push, tbl[i].pop, tbl[i].din, 3'b000);
      clr = 0;
      chk("tbl_count", count, tbl[i].cnt);
      chk("tbl_full", full, tbl[i].full);
      chk("tbl_empty", empty, tbl[i].empty);
      chk("tbl_overrun", overrun, tbl[i].over);
      chk("tbl_dout", dout, tbl[i].dout);
    end

    // Randomized traffic against the model.
    for (int i = 0; i < 2000; i++) begin
      int pbias;
      pbias = ((i / 250) % 2 == 0) ? 70 : 30;
      if ($urandom % 150 == 0) en = ~en;
      clr   = ($urandom % 60 == 0);
      ovc   = ($urandom % 6 == 0);
      if (i % 100 == 0) thr = 5'($urandom_range(0, 16));
      push  = ($urandom % 100) < 32'(pbias);
      pop   = ($urandom % 100) < 32'(100 - pbias);
      din   = 8'($urandom);
      errin = ($urandom % 4 == 0) ? 3'($urandom) : 3'b000;
      step();
      if (i == 1000) begin
        push = 0; pop = 0; clr = 0;
        async_reset();
      end
    end
    clr = 0; ovc = 0; push = 0; pop = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
